// File: rtl/jpeg_stage_pkg.sv
// Shared definitions for the JPEG coefficient pipeline stages.
// The zig-zag ROM is also used by the decoder-side inverse stage.
package jpeg_stage_pkg;

  localparam int BLOCK_SIZE = 64;

  typedef logic [5:0] idx_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // ZZ_TABLE[k] is the natural (raster) index of zig-zag output position k
  localparam idx_t ZZ_TABLE [BLOCK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic idx_t zz(input idx_t k);
    return ZZ_TABLE[k];
  endfunction

endpackage

// File: rtl/zigzag_reorder_stage_if.sv
// TIE FIFO pop/push bundle seen by the reorder stage: upstream pop side,
// downstream push side and the end-of-block pulse.
interface zigzag_reorder_stage_if #(
  parameter int BITWIDTH = 16
);
  logic                TIE_FIFO_IN_PopReq;
  logic [BITWIDTH-1:0] TIE_FIFO_IN;
  logic                TIE_FIFO_IN_Empty;
  logic                TIE_FIFO_OUT_PushReq;
  logic [BITWIDTH-1:0] TIE_FIFO_OUT;
  logic                TIE_FIFO_OUT_Full;
  logic                BLK_DONE;

  modport master (
    output TIE_FIFO_IN_PopReq,
    input  TIE_FIFO_IN,
    input  TIE_FIFO_IN_Empty,
    output TIE_FIFO_OUT_PushReq,
    output TIE_FIFO_OUT,
    input  TIE_FIFO_OUT_Full,
    output BLK_DONE
  );

  modport slave (
    input  TIE_FIFO_IN_PopReq,
    output TIE_FIFO_IN,
    output TIE_FIFO_IN_Empty,
    input  TIE_FIFO_OUT_PushReq,
    input  TIE_FIFO_OUT,
    output TIE_FIFO_OUT_Full,
    input  BLK_DONE
  );
endinterface

// File: rtl/zigzag_reorder_stage.sv
// Pops a raster-order 8x8 coefficient block into a local buffer, then pushes
// it downstream in JPEG zig-zag order (or natural order when ZZ_ENABLE=0).
module zigzag_reorder_stage
  import jpeg_stage_pkg::*;
#(
  parameter int BITWIDTH  = 16,
  parameter bit ZZ_ENABLE = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  zigzag_reorder_stage_if.master bus
);

  state_t state_reg, state_next;
  idx_t   wcnt_reg, wcnt_next;
  idx_t   rcnt_reg, rcnt_next;
  idx_t   rd_idx;
  logic   pop, push, done;

  logic [BITWIDTH-1:0] coef_buf [BLOCK_SIZE];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= FILL;
      wcnt_reg  <= '0;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    rcnt_next  = rcnt_reg;
    pop        = 1'b0;
    push       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      FILL: begin
        pop = !bus.TIE_FIFO_IN_Empty;
        if (pop) begin
          wcnt_next = wcnt_reg + 6'd1;
          if (wcnt_reg == idx_t'(BLOCK_SIZE - 1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        push = !bus.TIE_FIFO_OUT_Full;
        if (push) begin
          rcnt_next = rcnt_reg + 6'd1;
          if (rcnt_reg == idx_t'(BLOCK_SIZE - 1)) begin
            done       = 1'b1;
            state_next = FILL;
          end
        end
      end
    endcase
    // Requests are suppressed during reset; the registers still see RST
    if (RST) begin
      pop  = 1'b0;
      push = 1'b0;
      done = 1'b0;
    end
  end

  // Buffer has no reset: every word is rewritten before it is drained
  always_ff @(posedge CLK) begin
    if (pop) coef_buf[wcnt_reg] <= bus.TIE_FIFO_IN;
  end

  always_comb begin
    rd_idx = zz(6'd0);
    if (state_reg == DRAIN) rd_idx = ZZ_ENABLE ? zz(rcnt_reg) : rcnt_reg;
  end

  assign bus.TIE_FIFO_IN_PopReq   = pop;
  assign bus.TIE_FIFO_OUT_PushReq = push;
  assign bus.BLK_DONE             = done;
  assign bus.TIE_FIFO_OUT         = RST ? '0 : coef_buf[rd_idx];

endmodule

// File: tb/tb_zigzag_reorder_stage.sv
// Directed bench: a zig-zag instance and a pass-through instance share one
// upstream queue model and one downstream full flag.
module tb_zigzag_reorder_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty_s, full_s;
  logic [15:0] in_s;

  always #5 clk = ~clk;

  zigzag_reorder_stage_if #(.BITWIDTH(16)) ifc_zz ();
  zigzag_reorder_stage_if #(.BITWIDTH(16)) ifc_nat ();

  assign ifc_zz.TIE_FIFO_IN        = in_s;
  assign ifc_zz.TIE_FIFO_IN_Empty  = empty_s;
  assign ifc_zz.TIE_FIFO_OUT_Full  = full_s;
  assign ifc_nat.TIE_FIFO_IN       = in_s;
  assign ifc_nat.TIE_FIFO_IN_Empty = empty_s;
  assign ifc_nat.TIE_FIFO_OUT_Full = full_s;

  zigzag_reorder_stage #(.BITWIDTH(16), .ZZ_ENABLE(1'b1)) dut_zz (
    .CLK(clk), .RST(rst), .bus(ifc_zz)
  );
  zigzag_reorder_stage #(.BITWIDTH(16), .ZZ_ENABLE(1'b0)) dut_nat (
    .CLK(clk), .RST(rst), .bus(ifc_nat)
  );

  int zz_ref [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct {
    int          pos;
    logic [15:0] exp_zz;
    logic [15:0] exp_nat;
  } vec_t;
  vec_t vecs [12];

  logic [15:0] up_mem [256];
  int up_head, up_tail;
  logic empty_force, full_force;

  logic [15:0] push_log [256];
  logic [15:0] nat_log [256];
  int push_cyc [256];
  int pop_cyc [256];
  int done_cyc [8];
  int n_push, n_pop, n_done, cyc, viol;
  logic        last_pop, last_push, last_done;
  logic [15:0] last_out;

  int n_checks, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %-20s ok   got 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      up_mem[up_tail] = base + 16'(i);
      up_tail++;
    end
  endtask

  task automatic clear_logs();
    n_push = 0; n_pop = 0; n_done = 0;
    up_head = 0; up_tail = 0;
  endtask

  // One clock: drive at negedge, sample 1 time unit later, advance at posedge
  task automatic tick();
    logic pop_x, push_x;
    empty_s = (up_head == up_tail) || empty_force;
    in_s    = up_mem[up_head];
    full_s  = full_force;
    #1;
    last_pop  = ifc_zz.TIE_FIFO_IN_PopReq;
    last_push = ifc_zz.TIE_FIFO_OUT_PushReq;
    last_done = ifc_zz.BLK_DONE;
    last_out  = ifc_zz.TIE_FIFO_OUT;
    if (last_pop && empty_s) viol++;
    if (last_push && full_s) viol++;
    if (ifc_nat.TIE_FIFO_IN_PopReq != last_pop || ifc_nat.TIE_FIFO_OUT_PushReq != last_push ||
        ifc_nat.BLK_DONE != last_done) viol++;
    pop_x  = last_pop && !empty_s;
    push_x = last_push && !full_s;
    if (pop_x && n_pop < 256) begin
      pop_cyc[n_pop] = cyc;
      n_pop++;
    end
    if (push_x && n_push < 256) begin
      push_log[n_push] = last_out;
      nat_log[n_push]  = ifc_nat.TIE_FIFO_OUT;
      push_cyc[n_push] = cyc;
      n_push++;
    end
    if (last_done) begin
      if (n_done < 8) done_cyc[n_done] = cyc;
      n_done++;
      if (!push_x) viol++;
    end
    @(posedge clk);
    if (pop_x) up_head++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_pushes(input int target, input int budget);
    int b = 0;
    while (n_push < target && b < budget) begin
      tick();
      b++;
    end
  endtask

  initial begin
    int errs, errs_nat, b, held_bad;
    logic [15:0] hold_first;
    n_checks = 0; n_pass = 0; viol = 0; cyc = 0;
    empty_force = 1'b0; full_force = 1'b0;
    empty_s = 1'b1; full_s = 1'b0; in_s = '0;
    clear_logs();

    vecs[0]  = '{0,  16'h0000, 16'h0000};
    vecs[1]  = '{1,  16'h0001, 16'h0001};
    vecs[2]  = '{2,  16'h0008, 16'h0002};
    vecs[3]  = '{3,  16'h0010, 16'h0003};
    vecs[4]  = '{4,  16'h0009, 16'h0004};
    vecs[5]  = '{5,  16'h0002, 16'h0005};
    vecs[6]  = '{6,  16'h0003, 16'h0006};
    vecs[7]  = '{7,  16'h000A, 16'h0007};
    vecs[8]  = '{20, 16'h0028, 16'h0014};
    vecs[9]  = '{35, 16'h0038, 16'h0023};
    vecs[10] = '{62, 16'h003E, 16'h003E};
    vecs[11] = '{63, 16'h003F, 16'h003F};

    @(negedge clk);
    // Reset with data waiting upstream: no request may be raised
    rst = 1'b1;
    load(16'h0777, 4);
    repeat (3) tick();
    check("rst_popreq", 32'(last_pop), 32'd0);
    check("rst_pushreq", 32'(last_push), 32'd0);
    check("rst_blk_done", 32'(last_done), 32'd0);
    check("rst_out", 32'(last_out), 32'd0);
    rst = 1'b0;
    clear_logs();

    // Block 0..63, both orders from one stimulus
    load(16'h0000, 64);
    run_pushes(64, 300);
    check("t1_pops", n_pop, 64);
    check("t1_pop_span", pop_cyc[63] - pop_cyc[0], 63);
    check("t1_first_push_lat", push_cyc[0] - pop_cyc[63], 1);
    check("t1_push_count", n_push, 64);
    check("t1_push_span", push_cyc[63] - push_cyc[0], 63);
    check("t1_done_count", n_done, 1);
    check("t1_done_cycle", done_cyc[0], push_cyc[63]);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1_zz_pos%0d", vecs[i].pos), 32'(push_log[vecs[i].pos]), 32'(vecs[i].exp_zz));
      check($sformatf("t2_nat_pos%0d", vecs[i].pos), 32'(nat_log[vecs[i].pos]), 32'(vecs[i].exp_nat));
    end
    errs = 0; errs_nat = 0;
    for (int k = 0; k < 64; k++) begin
      if (push_log[k] !== 16'(zz_ref[k])) errs++;
      if (nat_log[k] !== 16'(k)) errs_nat++;
    end
    check("t1_zz_all_errs", errs, 0);
    check("t2_nat_all_errs", errs_nat, 0);

    // Full asserted for 10 cycles after the 5th push
    clear_logs();
    load(16'h0000, 64);
    run_pushes(5, 300);
    full_force = 1'b1;
    held_bad = 0;
    hold_first = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) hold_first = last_out;
      if (last_push || last_out !== 16'h0002) held_bad++;
    end
    full_force = 1'b0;
    run_pushes(64, 300);
    check("t3_hold_out", 32'(hold_first), 32'h0002);
    check("t3_hold_bad", held_bad, 0);
    check("t3_resume0", 32'(push_log[5]), 32'h0002);
    check("t3_resume1", 32'(push_log[6]), 32'h0003);
    check("t3_resume2", 32'(push_log[7]), 32'h000A);
    check("t3_push_count", n_push, 64);

    // Empty every other cycle during fill
    clear_logs();
    load(16'h0000, 64);
    b = 0;
    while (n_pop < 64 && b < 300) begin
      empty_force = b[0];
      tick();
      b++;
    end
    empty_force = 1'b0;
    run_pushes(64, 300);
    check("t4_pops", n_pop, 64);
    check("t4_pop_span", pop_cyc[63] - pop_cyc[0], 126);
    errs = 0;
    for (int k = 0; k < 64; k++) if (push_log[k] !== 16'(zz_ref[k])) errs++;
    check("t4_zz_all_errs", errs, 0);
    check("t4_push_count", n_push, 64);

    // Reset after 20 pops discards the partial block
    clear_logs();
    load(16'h0500, 64);
    repeat (20) tick();
    check("t5_pops_before_rst", n_pop, 20);
    rst = 1'b1;
    tick();
    check("t5_rst_popreq", 32'(last_pop), 32'd0);
    rst = 1'b0;
    up_head = up_tail;
    repeat (5) tick();
    check("t5_no_push", n_push, 0);
    load(16'h1000, 64);
    run_pushes(64, 300);
    check("t5_first", 32'(push_log[0]), 32'h1000);
    check("t5_second", 32'(push_log[1]), 32'h1001);
    check("t5_third", 32'(push_log[2]), 32'h1008);
    errs = 0;
    for (int k = 0; k < 64; k++) if (push_log[k] !== 16'h1000 + 16'(zz_ref[k])) errs++;
    check("t5_zz_all_errs", errs, 0);

    // Two blocks back to back
    clear_logs();
    load(16'h2000, 64);
    load(16'h3000, 64);
    repeat (256) tick();
    check("t6_done_count", n_done, 2);
    check("t6_done_spacing", done_cyc[1] - done_cyc[0], 128);
    check("t6_second_pop_lat", pop_cyc[64] - done_cyc[0], 1);
    check("t6_push_count", n_push, 128);
    check("t6_blk1_last", 32'(push_log[63]), 32'h203F);
    check("t6_blk2_first", 32'(push_log[64]), 32'h3000);
    check("t6_blk2_third", 32'(push_log[66]), 32'h3008);
    check("t6_blk2_last", 32'(push_log[127]), 32'h303F);

    check("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zigzag_reorder_stage.md
Name: zigzag_reorder_stage

Overview:
- Pipeline stage that drains the B2C inter-stage queue from its pop side.
- Pops one 8x8 block of 64 16-bit coefficients in natural raster order into a local buffer.
- Pushes the block in JPEG zig-zag order into the next inter-stage queue through the same TIE FIFO push protocol.
- Acts as the reader end of the upstream queue and the writer end of the downstream queue, replacing the software pop/reorder/push loop.

Parameters:
- BITWIDTH, 16, coefficient width; must match both adjacent queues.
- ZZ_ENABLE, 1, 1 = zig-zag output order; 0 = natural-order pass-through for debug.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  reset, synchronous, active-high.
- TIE_FIFO_IN_PopReq  output  1  pop request to the upstream queue.
- TIE_FIFO_IN  input  BITWIDTH  upstream head word; valid combinationally while Empty=0.
- TIE_FIFO_IN_Empty  input  1  upstream queue empty.
- TIE_FIFO_OUT_PushReq  output  1  push request to the downstream queue.
- TIE_FIFO_OUT  output  BITWIDTH  push data.
- TIE_FIFO_OUT_Full  input  1  downstream queue full.
- BLK_DONE  output  1  one-cycle pulse in the cycle the 64th word of a block is pushed.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, sampled on the CLK posedge.
- Reset effects:
  - state=FILL, wcnt=0, rcnt=0.
  - PopReq, PushReq and BLK_DONE are all 0 while RST=1.
  - TIE_FIFO_OUT=0 while RST=1.
  - Buffer contents are not reset.
- Protocol rules (both sides):
  - A transfer occurs on a posedge where the request is 1 and the flag (Empty or Full) is 0.
  - The request is driven combinationally: PopReq = (state==FILL) && !Empty; PushReq = (state==DRAIN) && !Full.
  - PopReq is never asserted while Empty=1. PushReq is never asserted while Full=1.
- State FILL:
  - Each pop writes TIE_FIFO_IN to buf[wcnt], then wcnt increments.
  - On the pop with wcnt==63: wcnt wraps to 0 and the next state is DRAIN.
  - Empty gaps stall FILL with no side effects.
- State DRAIN:
  - TIE_FIFO_OUT = buf[ZZ[rcnt]] when ZZ_ENABLE=1; buf[rcnt] otherwise. It is a combinational read of the registered buffer.
  - Each push increments rcnt.
  - On the push with rcnt==63: rcnt wraps to 0, BLK_DONE=1 in that same cycle, and the next state is FILL.
  - Full stalls DRAIN. TIE_FIFO_OUT holds its value while stalled.
  - TIE_FIFO_OUT outside DRAIN: holds buf[ZZ[0]] (don't-care to the checker, but must not be X after the first block).
- No overlap between phases: no pop occurs during DRAIN and no push during FILL. The first push is exactly 1 cycle after the 64th pop when Full=0.
- Throughput: 128 cycles per block minimum, i.e. one transfer per cycle with no stalls.
- Reset mid-operation discards the partial block. Words already popped are lost, by design. After RST deasserts, the next pop is stored at buf[0].
- Simultaneous Empty and Full: only the side belonging to the current state matters.
- Zig-zag table ZZ[k] gives the natural index for output position k (standard JPEG):
  - 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,
  - 12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
  - 35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
  - 58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Counters are 6 bits and wrap modulo 64 naturally.

Decomposition:
- Shared package jpeg_stage_pkg holds:
  - BLOCK_SIZE=64;
  - the 6-bit index type;
  - the state enum {FILL, DRAIN};
  - the ZZ constant array, a 64 x 6-bit ROM function.
- The ZZ table is reused by the decoder-side inverse stage.
- No sub-module is needed. The 64 x BITWIDTH buffer is an inline register array, matching the queue storage style.

Test Plan:
1. Upstream preloaded with 0x0000..0x003F, Full=0 → pops 64 consecutive cycles, then pushes 0x0000,0x0001,0x0008,0x0010,0x0009,0x0002,…,0x0037,0x003E,0x003F. BLK_DONE pulses with 0x003F.
2. ZZ_ENABLE=0, same stimulus → pushes 0x0000..0x003F in order.
3. Full forced high for 10 cycles after the 5th push (rcnt=5) → PushReq=0 and TIE_FIFO_OUT held at 0x0002 throughout. Resumes with 0x0002,0x0003,0x000A. Still 64 pushes total.
4. Upstream Empty toggles every other cycle during fill → exactly 64 pops over 127 cycles. Output order is identical to test 1, and no pop is issued while Empty=1.
5. RST pulsed for 1 cycle after 20 pops → no push occurs. A fresh block 0x1000..0x103F then produces 0x1000,0x1001,0x1008,…. No stale words appear.
6. Two blocks back-to-back, with the second preloaded → second-block pops start the cycle after the first BLK_DONE. Exactly two BLK_DONE pulses over 256 cycles.
